// File: rtl/sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : sweep_gen
// Purpose  : Frequency-sweep sequencer feeding the NCO frequency control word.
//            Steps ctrl from f_start toward f_stop (up or down) in f_step
//            increments, holding each point dwell+1 clocks. One-shot or
//            continuous (repeating) chirps.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, abort        - begin a sweep (ignored while busy) / stop now
//            f_start, f_stop     - first point and sweep limit (unsigned)
//            f_step              - step magnitude (unsigned)
//            dwell               - each point is held dwell+1 cycles
//            continuous          - 1 = repeat until abort, 0 = one-shot
//            pingpong            - (SWEEP_PINGPONG_EN only) reverse direction at
//                                  each end instead of jumping back to f_start
//            ctrl                - registered frequency control word
//            busy, done, wrap    - in-progress flag, one-shot end pulse,
//                                  continuous restart/reversal pulse
// Options  : define SWEEP_PINGPONG_EN to add the pingpong port and feature.
// Revision : 1.0 - initial release
// ============================================================================
module sweep_gen #(
    parameter int WIDTH   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   f_start,
    input  logic [WIDTH-1:0]   f_stop,
    input  logic [WIDTH-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
`ifdef SWEEP_PINGPONG_EN
    input  logic               pingpong,
`endif
    output logic [WIDTH-1:0]   ctrl,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_ctrl;
    logic               r_busy;
    logic               r_done;
    logic               r_wrap;
    logic [DWELL_W-1:0] r_cnt;

    // Latched sweep configuration. r_org is the end the current leg started
    // from, r_lim the end it is heading toward; they only swap in ping-pong.
    logic [WIDTH-1:0]   r_org;
    logic [WIDTH-1:0]   r_lim;
    logic [WIDTH-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_cont;
    logic               r_up;

    logic [WIDTH-1:0]   w_ctrl_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_wrap_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_load;
    logic               w_reverse;
    logic               w_pp_en;

    // Candidate points in one extra bit so a carry/borrow is visible and ctrl
    // can never wrap modulo 2^WIDTH.
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH:0]     w_fwd_nxt;
    logic [WIDTH:0]     w_rev_nxt;
    logic               w_term;
    logic               w_rev_ok;

`ifdef SWEEP_PINGPONG_EN
    logic               r_pp;
    assign w_pp_en = r_cont & r_pp;
`else
    assign w_pp_en = 1'b0;
`endif

    assign w_sum     = {1'b0, r_ctrl} + {1'b0, r_step};
    assign w_dif     = {1'b0, r_ctrl} - {1'b0, r_step};
    assign w_fwd_nxt = r_up ? w_sum : w_dif;
    assign w_rev_nxt = r_up ? w_dif : w_sum;

    assign w_term = (r_step == '0) ||
                    (r_up  ? (w_sum > {1'b0, r_lim})
                           : (w_dif[WIDTH] || (w_dif[WIDTH-1:0] < r_lim)));

    // First point of the reversed leg, checked against the opposite end. If
    // it is not a legal point (single-point sweep or zero step) the end point
    // is simply held for another dwell.
    assign w_rev_ok = (r_step != '0) &&
                      (r_up  ? (!w_dif[WIDTH] && (w_dif[WIDTH-1:0] >= r_org))
                             : (w_sum <= {1'b0, r_org}));

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_reverse   = 1'b0;

        if (abort) begin
            // Abort beats start and terminal handling; ctrl keeps its value.
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_load      = 1'b1;
                        w_ctrl_nxt  = f_start;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = dwell;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - DWELL_W'(1);
                    end else if (!w_term) begin
                        w_ctrl_nxt = w_fwd_nxt[WIDTH-1:0];
                        w_cnt_nxt  = r_dwell;
                    end else if (r_cont) begin
                        w_wrap_nxt = 1'b1;
                        w_cnt_nxt  = r_dwell;
                        if (w_pp_en) begin
                            w_reverse  = 1'b1;
                            w_ctrl_nxt = w_rev_ok ? w_rev_nxt[WIDTH-1:0] : r_ctrl;
                        end else begin
                            w_ctrl_nxt = r_org;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
            r_org   <= '0;
            r_lim   <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_cont  <= 1'b0;
            r_up    <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            r_pp    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_org   <= f_start;
                r_lim   <= f_stop;
                r_step  <= f_step;
                r_dwell <= dwell;
                r_cont  <= continuous;
                r_up    <= (f_stop >= f_start);
`ifdef SWEEP_PINGPONG_EN
                r_pp    <= pingpong;
`endif
            end else if (w_reverse) begin
                r_org <= r_lim;
                r_lim <= r_org;
                r_up  <= ~r_up;
            end
        end
    end

    assign ctrl = r_ctrl;
    assign busy = r_busy;
    assign done = r_done;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sweep_gen
// Purpose  : Self-checking bench for sweep_gen. Expected per-cycle traces are
//            built from the list of sweep points computed arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sweep_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic        continuous;
`ifdef SWEEP_PINGPONG_EN
    logic        pingpong;
`endif
    logic [31:0] ctrl;
    logic        busy;
    logic        done;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    logic [31:0] e_ctrl[$];
    bit          e_busy[$];
    bit          e_done[$];
    bit          e_wrap[$];

    sweep_gen #(.WIDTH(32), .DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .continuous (continuous),
`ifdef SWEEP_PINGPONG_EN
        .pingpong   (pingpong),
`endif
        .ctrl       (ctrl),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_e(input logic [31:0] c, input bit b, input bit d, input bit w);
        e_ctrl.push_back(c);
        e_busy.push_back(b);
        e_done.push_back(d);
        e_wrap.push_back(w);
    endtask

    // Expected outputs for each cycle after the start edge.
    task automatic build_trace(input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] st, input int dw, input bit cont,
                               input bit pp, input int maxlen, input int tail);
        longint lfs, lfe, lst, p, n;
        longint pts[$];
        longint leg[$];
        bit     up, fwd, first;
        e_ctrl.delete(); e_busy.delete(); e_done.delete(); e_wrap.delete();
        lfs = fs; lfe = fe; lst = st;
        up  = (lfe >= lfs);
        p   = lfs;
        pts.push_back(p);
        if (lst != 0) begin
            forever begin
                n = up ? p + lst : p - lst;
                if (up ? (n > lfe) : (n < lfe)) break;
                p = n;
                pts.push_back(p);
            end
        end
        if (!cont) begin
            foreach (pts[i])
                for (int r = 0; r <= dw; r++) push_e(pts[i][31:0], 1'b1, 1'b0, 1'b0);
            push_e(pts[pts.size()-1][31:0], 1'b0, 1'b1, 1'b0);
            for (int t = 0; t < tail; t++) push_e(pts[pts.size()-1][31:0], 1'b0, 1'b0, 1'b0);
        end else begin
            leg   = pts;
            fwd   = 1'b1;
            first = 1'b1;
            while (e_ctrl.size() < maxlen) begin
                foreach (leg[i])
                    for (int r = 0; r <= dw; r++)
                        push_e(leg[i][31:0], 1'b1, 1'b0, (!first && i == 0 && r == 0));
                first = 1'b0;
                if (pp) begin
                    fwd = !fwd;
                    leg.delete();
                    if (fwd) begin
                        for (int i = 1; i < pts.size(); i++) leg.push_back(pts[i]);
                    end else begin
                        for (int i = pts.size() - 2; i >= 0; i--) leg.push_back(pts[i]);
                    end
                    if (leg.size() == 0) leg.push_back(pts[0]);
                end
            end
        end
    endtask

    // Truncate after cycle k (abort or reset there) and append quiet cycles.
    task automatic cut_trace(input int k, input logic [31:0] hold);
        while (e_ctrl.size() > k + 1) begin
            void'(e_ctrl.pop_back()); void'(e_busy.pop_back());
            void'(e_done.pop_back()); void'(e_wrap.pop_back());
        end
        for (int t = 0; t < 2; t++) push_e(hold, 1'b0, 1'b0, 1'b0);
    endtask

    // Entered and left at a negedge; start is driven in the current cycle.
    task automatic run_sweep(input string name, input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input int dw, input bit cont, input bit pp,
                             input int maxlen, input int tail, input int abort_at,
                             input int rst_at, input bit poke);
        build_trace(fs, fe, st, dw, cont, pp, maxlen, tail);
        if (abort_at >= 0 && abort_at < e_ctrl.size())
            cut_trace(abort_at, e_ctrl[abort_at]);
        else if (rst_at >= 0 && rst_at < e_ctrl.size())
            cut_trace(rst_at, 32'h0);
        f_start    = fs;
        f_stop     = fe;
        f_step     = st;
        dwell      = 16'(dw);
        continuous = cont;
`ifdef SWEEP_PINGPONG_EN
        pingpong   = pp;
`endif
        start      = 1'b1;
        for (int c = 0; c < e_ctrl.size(); c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("%s ctrl[%0d]", name, c), ctrl, e_ctrl[c]);
            check_eq($sformatf("%s busy[%0d]", name, c), 32'(busy), 32'(e_busy[c]));
            check_eq($sformatf("%s done[%0d]", name, c), 32'(done), 32'(e_done[c]));
            check_eq($sformatf("%s wrap[%0d]", name, c), 32'(wrap), 32'(e_wrap[c]));
            start = poke && e_busy[c] && ($urandom_range(0, 2) == 0);
            abort = (c == abort_at);
            rst   = (c == rst_at);
            if (c == 0) begin
                f_start    = $urandom;
                f_stop     = $urandom;
                f_step     = $urandom;
                dwell      = 16'($urandom);
                continuous = $urandom_range(0, 1) == 1;
`ifdef SWEEP_PINGPONG_EN
                pingpong   = $urandom_range(0, 1) == 1;
`endif
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        logic [31:0] fs, fe, st;
        int          r, kind, dw, ab, rs;
        bit          cont, pp;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0; continuous = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        pingpong = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset ctrl", ctrl, 32'h0);
        check_eq("reset busy", 32'(busy), 32'h0);
        check_eq("reset done", 32'(done), 32'h0);
        check_eq("reset wrap", 32'(wrap), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep("up_oneshot",  32'd100, 32'd260, 32'd50, 2, 0, 0, 0, 1, -1, -1, 0);
        run_sweep("down",        32'd1000, 32'd700, 32'd100, 0, 0, 0, 0, 0, -1, -1, 0);
        run_sweep("ovf_guard",   32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 0, 0, 0, 0, 1, -1, -1, 0);
        run_sweep("cont_abort",  32'd10, 32'd30, 32'd10, 0, 1, 0, 12, 0, 4, -1, 0);
        run_sweep("step_zero",   32'd77, 32'd500, 32'd0, 3, 0, 0, 0, 1, -1, -1, 0);
        run_sweep("start_in_run", 32'd5, 32'd80, 32'd15, 1, 0, 0, 0, 1, -1, -1, 1);
        run_sweep("rst_mid",     32'd300, 32'd100, 32'd40, 1, 0, 0, 0, 1, -1, 5, 0);
        run_sweep("single_pt",   32'd42, 32'd42, 32'd7, 2, 0, 0, 0, 1, -1, -1, 0);
        run_sweep("borrow",      32'd150, 32'd0, 32'd100, 0, 0, 0, 0, 1, -1, -1, 0);
`ifdef SWEEP_PINGPONG_EN
        run_sweep("pingpong",    32'd0, 32'd10, 32'd5, 0, 1, 1, 14, 0, 12, -1, 0);
`endif

        for (int it = 0; it < 40; it++) begin
            r    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 5000);
            kind = $urandom_range(0, 3);
            case (kind)
                0:       begin fs = 32'hFFFFFFFF - 32'(r); fe = 32'hFFFFFFFF; end
                1:       begin fs = 32'(r); fe = 32'h0; end
                2:       begin fs = $urandom_range(0, 32'hFFFF0000); fe = fs + 32'(r); end
                default: begin fs = $urandom_range(32'h10000, 32'hFFFFFFFF); fe = fs - 32'(r); end
            endcase
            st   = ($urandom_range(0, 7) == 0) ? 32'h0
                                               : 32'(r / 10 + $urandom_range(1, r / 4 + 64));
            dw   = $urandom_range(0, 3);
            cont = ($urandom_range(0, 2) == 0);
`ifdef SWEEP_PINGPONG_EN
            pp   = $urandom_range(0, 1) == 1;
`else
            pp   = 1'b0;
`endif
            if (cont)
                ab = $urandom_range(0, 35);
            else
                ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
            rs = (ab < 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1;
            run_sweep($sformatf("rand%0d", it), fs, fe, st, dw, cont, pp, 40,
                      $urandom_range(0, 2), ab, rs, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sweep_gen.md
Name: sweep_gen

Overview:
Frequency-sweep sequencer that drives the 32-bit frequency control word of the NCO directly, so it acts as the oscillator's upstream stage.
Steps the control word from a start value to a stop value, up or down, in fixed increments. Each point is held for a programmable number of clocks.
Supports one-shot and continuous (repeating) chirps. Output is registered and feeds the NCO ctrl input with no further logic.

Parameters:
WIDTH, 32, width of frequency words (f_start, f_stop, f_step, ctrl)
DWELL_W, 16, width of dwell counter / dwell input

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; ignored while busy
abort  input  1  stop the sweep immediately; return to IDLE
f_start  input  WIDTH  first sweep point, unsigned
f_stop  input  WIDTH  sweep limit, unsigned; direction is up if f_stop >= f_start, else down
f_step  input  WIDTH  unsigned increment magnitude
dwell  input  DWELL_W  each point is held dwell+1 cycles
continuous  input  1  1 = repeat the sweep until abort; 0 = one-shot
ctrl  output  WIDTH  frequency control word to the NCO, registered
busy  output  1  high while the sweep is in progress
done  output  1  one-cycle pulse at one-shot completion
wrap  output  1  one-cycle pulse on each continuous restart

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: ctrl=0, busy=0, done=0, wrap=0, state=IDLE, dwell counter=0.
- States: IDLE, RUN.
- Starting a sweep:
  - IDLE with start=1 at edge N: latch f_start, f_stop, f_step, dwell, continuous and direction.
  - ctrl=f_start from cycle N+1; busy=1 from N+1; enter RUN.
- Latched configuration: input changes during RUN are ignored until the next start.
- RUN dwell:
  - Counter loads the latched dwell value at each new point and decrements every cycle.
  - The point ends in the cycle where counter==0, so ctrl is held exactly dwell+1 cycles.
- Next point at end of dwell:
  - nxt = ctrl + step (up) or ctrl - step (down), computed in WIDTH+1 bits.
  - Terminal if step==0, or (up and nxt > f_stop, including carry out), or (down and borrow or nxt < f_stop).
  - Non-terminal: ctrl <= nxt[WIDTH-1:0]. Sweep points are therefore f_start, f_start±step, ..., the last point not passing f_stop. ctrl never wraps modulo 2^WIDTH.
- Terminal, one-shot: next cycle state=IDLE, busy=0, done=1 for one cycle; ctrl holds the last point.
- Terminal, continuous: ctrl <= f_start, wrap=1 for one cycle, stay in RUN, reload dwell.
- abort=1 in any state: next cycle state=IDLE, busy=0, no done, no wrap; ctrl holds its current value. Abort takes priority over terminal and over start in the same cycle.
- start in RUN: ignored.
- start on the same edge as one-shot completion: ignored, because state is still RUN on that edge. A new start is accepted on the IDLE cycle where done=1.
- rst mid-sweep: all outputs return to reset values on the next edge, including ctrl=0.
- f_start==f_stop: a single point; terminal after its dwell.

Optional Feature:
- Macro: SWEEP_PINGPONG_EN.
- Defined:
  - Extra input port pingpong (1 bit), latched at start.
  - When continuous=1 and pingpong=1, a terminal point does not jump back to f_start. Instead, direction reverses and the sweep heads back toward f_start using the same step and terminal rules, with the roles of f_start and f_stop swapped.
  - wrap pulses on each reversal. The end point is held once (dwell+1 cycles) and is not repeated.
- Undefined: pingpong port absent; continuous mode always restarts at f_start.

Test Plan:
1. Up sweep, one-shot: f_start=100, f_step=50, f_stop=260, dwell=2, start at edge 0 -> ctrl=100 on cycles 1-3, 150 on 4-6, 200 on 7-9, 250 on 10-12; done=1 and busy=0 at cycle 13; ctrl stays 250.
2. Down sweep: f_start=1000, f_stop=700, f_step=100, dwell=0 -> ctrl 1000, 900, 800, 700 on consecutive cycles; done on the next cycle.
3. Overflow guard: f_start=32'hFFFFFF00, f_stop=32'hFFFFFFFF, f_step=32'h80, dwell=0 -> ctrl FFFFFF00, then FFFFFF80, then done; never 0x00000000.
4. Continuous plus abort: f_start=10, f_step=10, f_stop=30, dwell=0, continuous=1 -> ctrl 10, 20, 30, 10(wrap=1), 20, ...; abort while ctrl=20 -> next cycle busy=0, ctrl=20, done=0.
5. Corner cases:
   - f_step=0, dwell=3, one-shot -> ctrl=f_start for 4 cycles, then done.
   - start pulsed during RUN -> no effect.
   - rst mid-sweep -> ctrl=0, busy=0 next cycle.
6. (SWEEP_PINGPONG_EN) f_start=0, f_step=5, f_stop=10, dwell=0, continuous=1, pingpong=1 -> ctrl 0, 5, 10, 5, 0, 5, 10 ...; wrap=1 on the cycles showing the first 5 after 10 and the first 5 after 0.
